// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide issue block: FSM encoding,
// exception codes written to rstatus, and default parameters.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] EXC_MULT    = 32'd1;
    localparam logic [31:0] EXC_DIV     = 32'd2;
    localparam logic [31:0] EXC_TIMEOUT = 32'd3;

    localparam logic [4:0] RSTATUS_DEFAULT = 5'd30;
    localparam int         TIMEOUT_DEFAULT = 40;

endpackage

// File: rtl/multdiv_wait_counter.sv
// 6-bit wait counter for the BUSY phase; hit flags the last allowed wait cycle.
module multdiv_wait_counter #(
    parameter int TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [5:0] count,
    output logic       hit
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 6'd1;
        end
    end

    assign hit = (count == 6'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue.sv
// Pipeline-side initiator for the shared mult/div unit: latches a request,
// pulses the start strobe, stalls until completion or timeout, then writes back.
module multdiv_issue
    import multdiv_pkg::*;
#(
    parameter int         DATA_W  = 32,
    parameter int         TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [4:0] RSTATUS = RSTATUS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_mult,
    input  logic              is_div,
    input  logic [DATA_W-1:0] operandA,
    input  logic [DATA_W-1:0] operandB,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] data_result,
    input  logic              data_resultRDY,
    input  logic              data_exception,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_operandA,
    output logic [DATA_W-1:0] data_operandB,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    state_t      state, state_nx;
    logic        req;
    logic        op_mult;
    logic [4:0]  rd_q;
    logic        cnt_clr, cnt_en, cnt_hit;
    logic [5:0]  wait_count;

    assign req = is_mult | is_div;

    multdiv_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (wait_count),
        .hit   (cnt_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = START;
            START:   state_nx = BUSY;
            BUSY:    if (data_resultRDY || cnt_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stall is combinational on the IDLE request so the instruction is frozen from its first cycle.
    always_comb begin
        stall   = (state == START) || (state == BUSY) || ((state == IDLE) && req);
        cnt_clr = (state == START);
        cnt_en  = (state == BUSY) && (wait_count != 6'h3F);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            data_operandA <= '0;
            data_operandB <= '0;
            op_mult       <= 1'b0;
            rd_q          <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            wb_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        data_operandA <= operandA;
                        data_operandB <= operandB;
                        rd_q          <= rd;
                        op_mult       <= is_mult;
                        ctrl_MULT     <= is_mult;
                        ctrl_DIV      <= ~is_mult;
                    end
                end
                BUSY: begin
                    // A completion in the last wait cycle beats the timeout.
                    if (data_resultRDY) begin
                        wb_valid <= 1'b1;
                        if (data_exception) begin
                            wb_rd   <= RSTATUS;
                            wb_data <= op_mult ? DATA_W'(EXC_MULT) : DATA_W'(EXC_DIV);
                        end else begin
                            wb_rd   <= rd_q;
                            wb_data <= data_result;
                        end
                    end else if (cnt_hit) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= RSTATUS;
                        wb_data  <= DATA_W'(EXC_TIMEOUT);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue: directed scenarios plus randomized operations
// checked cycle by cycle against a transaction-level timing model.
module tb_multdiv_issue;

    localparam int         TIMEOUT = 40;
    localparam logic [4:0] RSTATUS = 5'd30;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_mult, is_div;
    logic [31:0] operandA, operandB;
    logic [4:0]  rd;
    logic [31:0] data_result;
    logic        data_resultRDY, data_exception;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multdiv_issue #(.DATA_W(32), .TIMEOUT(TIMEOUT), .RSTATUS(RSTATUS)) dut (
        .clk            (clk),
        .reset          (reset),
        .is_mult        (is_mult),
        .is_div         (is_div),
        .operandA       (operandA),
        .operandB       (operandB),
        .rd             (rd),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctrl_MULT"}, ctrl_MULT, 0);
        chk({tag, ".ctrl_DIV"}, ctrl_DIV, 0);
        chk({tag, ".opA"}, data_operandA, 0);
        chk({tag, ".opB"}, data_operandB, 0);
        chk({tag, ".wb_valid"}, wb_valid, 0);
        chk({tag, ".wb_rd"}, wb_rd, 0);
        chk({tag, ".wb_data"}, wb_data, 0);
        chk({tag, ".stall"}, stall, 0);
    endtask

    // Idle cycles with no request; completion pulses must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            is_mult        = 1'b0;
            is_div         = 1'b0;
            data_resultRDY = 1'($urandom_range(0, 1));
            data_result    = $urandom;
            data_exception = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle.stall", stall, 0);
            chk("idle.wb_valid", wb_valid, 0);
            chk("idle.ctrl", {ctrl_MULT, ctrl_DIV}, 0);
            @(posedge clk); #1;
        end
    endtask

    // One operation from its request cycle (cycle 0) through its DONE cycle.
    // Expected behaviour derives from the request/RDY timeline alone.
    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int rdy_cyc, input logic [31:0] res,
                          input bit exc, input int stray_cyc, input bit hold_done);
        int          done_c;
        bit          got_rdy;
        logic [4:0]  erd;
        logic [31:0] edata;
        got_rdy = (rdy_cyc >= 2) && (rdy_cyc <= TIMEOUT + 1);
        done_c  = got_rdy ? rdy_cyc + 1 : TIMEOUT + 2;
        if (!got_rdy) begin
            erd = RSTATUS; edata = 32'd3;
        end else if (exc) begin
            erd = RSTATUS; edata = m ? 32'd1 : 32'd2;
        end else begin
            erd = r; edata = res;
        end
        for (int c = 0; c <= done_c; c++) begin
            logic req;
            req            = (c < done_c) || hold_done;
            is_mult        = req & m;
            is_div         = req & d;
            operandA       = (c == 0) ? a : $urandom;
            operandB       = (c == 0) ? b : $urandom;
            rd             = (c == 0) ? r : 5'($urandom);
            data_resultRDY = (c == rdy_cyc) || (c == stray_cyc);
            data_result    = (c == rdy_cyc) ? res : $urandom;
            data_exception = (c == rdy_cyc) ? exc : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall", stall, 32'(c < done_c));
            chk("ctrl_MULT", ctrl_MULT, 32'((c == 1) && m));
            chk("ctrl_DIV", ctrl_DIV, 32'((c == 1) && !m));
            chk("wb_valid", wb_valid, 32'(c == done_c));
            if (c >= 1) begin
                chk("data_operandA", data_operandA, a);
                chk("data_operandB", data_operandB, b);
            end
            if (c == done_c) begin
                chk("wb_rd", 32'(wb_rd), 32'(erd));
                chk("wb_data", wb_data, edata);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        is_mult = 1'b0; is_div = 1'b0;
        operandA = '0; operandB = '0; rd = '0;
        data_result = '0; data_resultRDY = 1'b0; data_exception = 1'b0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        run_op(1, 0, 32'd7, 32'd6, 5'd5, 4, 32'd42, 0, -1, 0);
        idle(1);
        run_op(0, 1, 32'd10, 32'd0, 5'd9, 35, 32'd123, 1, -1, 0);
        idle(1);
        run_op(0, 1, 32'd100, 32'd7, 5'd4, -1, 32'd0, 0, -1, 0);
        idle(1);
        run_op(1, 0, 32'h1234, 32'h5678, 5'd3, 3, 32'hFFFF_FFFF, 0, 1, 0);
        idle(1);

        for (int c = 0; c < 10; c++) begin
            is_mult = 1'b1; is_div = 1'b0;
            operandA = 32'd55; operandB = 32'd66; rd = 5'd12;
            data_resultRDY = 1'b0;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        is_mult = 1'b0;
        #1;
        chk_all_zero("reset_busy");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(4);
        run_op(1, 0, 32'd3, 32'd9, 5'd8, 6, 32'd27, 0, -1, 0);

        run_op(1, 1, 32'd2, 32'd2, 5'd1, 5, 32'd4, 0, -1, 1);
        run_op(0, 1, 32'd9, 32'd3, 5'd2, 2, 32'd3, 0, -1, 0);

        for (int i = 0; i < 15; i++) begin
            bit m, d, hold;
            m    = 1'($urandom_range(0, 1));
            d    = m ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = 1'($urandom_range(0, 1));
            run_op(m, d, $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 45)),
                   $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 1) ? 1 : -1, hold);
            if (!hold) idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Pipeline-side initiator for the shared multiply/divide unit. Accepts a decoded mult/div instruction from the execute stage and latches its operands. Issues a one-cycle ctrl_MULT/ctrl_DIV start pulse, then stalls the pipeline until the unit's data_resultRDY pulse or a timeout. It then presents one write-back beat, either to the destination register or, on exception/timeout, to rstatus.

## Interface
- TIMEOUT, 40: max BUSY cycles to wait for data_resultRDY before declaring a timeout.
- RSTATUS, 5'd30: register index written on exception/timeout.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; returns block to IDLE.
- is_mult  in  1  execute-stage instruction is mult (level, held while stalled).
- is_div  in  1  execute-stage instruction is div (level, held while stalled).
- operandA  in  32  rs value.
- operandB  in  32  rt value.
- rd  in  5  destination register.
- data_result  in  32  unit result, valid with data_resultRDY.
- data_resultRDY  in  1  single-cycle completion pulse from unit.
- data_exception  in  1  unit exception flag, sampled with data_resultRDY.
- ctrl_MULT  out  1  registered one-cycle start pulse for multiply.
- ctrl_DIV  out  1  registered one-cycle start pulse for divide.
- data_operandA  out  32  latched operand A, stable from START until return to IDLE.
- data_operandB  out  32  latched operand B, same stability.
- stall  out  1  freeze fetch/decode/execute.
- wb_valid  out  1  one-cycle write-back strobe.
- wb_rd  out  5  write-back register.
- wb_data  out  32  write-back data.

## Operation
- States: IDLE, START, BUSY, DONE (2-bit encoding).
- IDLE: when is_mult|is_div, latch operandA/B, rd, and op type (mult wins if both asserted), then go to START.
- START: ctrl_MULT or ctrl_DIV high for exactly this cycle. data_resultRDY is ignored here. Clear the wait counter. Go to BUSY.
- BUSY: the 6-bit wait counter increments each cycle.
  - If data_resultRDY: capture the result and go to DONE.
  - Else if counter == TIMEOUT-1: flag a timeout and go to DONE.
- DONE: wb_valid=1 for one cycle, then go to IDLE.
  - Normal: wb_rd=latched rd, wb_data=data_result.
  - data_exception: wb_rd=RSTATUS, wb_data=EXC_MULT (1) or EXC_DIV (2).
  - Timeout: wb_rd=RSTATUS, wb_data=EXC_TIMEOUT (3).
- stall = (state != IDLE && state != DONE) || (state == IDLE && (is_mult|is_div)). It is combinational on the IDLE request, so the requesting instruction is held from its first cycle.
- In DONE, stall=0 so the instruction retires. A new request seen in the DONE cycle is not accepted; it is accepted on the following IDLE cycle.
- data_resultRDY outside BUSY is ignored.
- Reset, asynchronous and possibly mid-operation:
  - State goes to IDLE and all registered outputs go to 0 (ctrl_MULT, ctrl_DIV, data_operandA/B, wb_valid, wb_rd, wb_data, counter, latches).
  - No start pulse is re-issued after reset.
  - stall is 0 unless a request is present.

## Timing
- Cycle 0: request seen in IDLE; stall=1; operands latched at end of cycle.
- Cycle 1: START; ctrl_X=1; data_operandA/B valid.
- Cycle 2 onward: BUSY. If data_resultRDY arrives in cycle k, wb_valid=1 in cycle k+1 and stall=0 in cycle k+1.
- Minimum latency from request to wb_valid: 3 cycles (RDY in first BUSY cycle).
- Timeout: wb_valid in cycle 2+TIMEOUT+... exactly cycle TIMEOUT+2 (counter 0..TIMEOUT-1 across cycles 2..TIMEOUT+1).
- Back-to-back: a second op can start at the earliest two cycles after DONE (DONE, then IDLE detect).

## Structure
- Package multdiv_pkg holds the state encoding (IDLE=0, START=1, BUSY=2, DONE=3), EXC_MULT, EXC_DIV, EXC_TIMEOUT, and the default RSTATUS.
- One sub-module: multdiv_wait_counter (6-bit counter with synchronous clear, enable, and async reset; outputs count and hit==TIMEOUT-1).
- Everything else is a single FSM plus operand/result latch registers in multdiv_issue.

## Test plan
- Mult normal: is_mult, A=7, B=6, rd=5; RDY with result 42 in cycle 4.
  - Required: ctrl_MULT only in cycle 1; stall cycles 0-4.
  - Required: wb_valid cycle 5 with rd=5, data=42.
- Div exception: is_div, A=10, B=0; RDY+exception in cycle 35.
  - Required: ctrl_DIV only in cycle 1.
  - Required: wb_valid cycle 36 with rd=30, data=2.
- Timeout: is_div, no RDY.
  - Required: wb_valid exactly cycle 42 (TIMEOUT=40) with rd=30, data=3; stall drops in cycle 42.
- Stray RDY: RDY pulse in cycle 1 (START) ignored; real RDY cycle 3 with result 0xFFFF_FFFF.
  - Required: wb_valid cycle 4 with data=0xFFFF_FFFF.
- Reset mid-BUSY: reset asserted cycle 10.
  - Required: all outputs 0 immediately (async); no wb_valid follows.
  - Required: a new is_mult after release gives ctrl_MULT one cycle after detection.
- Both flags: is_mult=is_div=1.
  - Required: ctrl_MULT pulses and ctrl_DIV stays 0.
  - Required: back-to-back second op gets ctrl pulse two cycles after the first wb_valid.
